link_tx_arbiter: RTL and testbench

//  Transmit-side controller for the 4-bit nibble link (data/valid/ack) feeding fpga_receiver.

---
 rtl/link_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/link_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_link_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and constants for the 4-bit nibble link transmit side.
package link_pkg;

  localparam int unsigned LINK_NIBBLE_W = 4;
  localparam int unsigned LINK_N_REQ    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } link_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1 (mod N).
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [$clog2(N)-1:0] o_grant_c,
  output logic                 o_any_c
);

  localparam int unsigned IDX_W = $clog2(N);

  int unsigned w_idx;

  always_comb begin
    o_grant_c = '0;
    o_any_c   = 1'b0;
    w_idx     = 0;
    // k runs 1..N so the previous winner is considered last
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(i_ptr) + k) % N;
      if (!o_any_c && i_req[IDX_W'(w_idx)]) begin
        o_any_c   = 1'b1;
        o_grant_c = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/link_tx_arbiter.sv
// Round-robin transmit controller for the valid/ack nibble link: one full
// handshake per beat, enforced idle gap, and timeout recovery in SEND/RELEASE.
module link_tx_arbiter
  import link_pkg::*;
#(
  parameter int unsigned N_REQ       = LINK_N_REQ,
  parameter int unsigned NIBBLE_W    = LINK_NIBBLE_W,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned GAP_CYC     = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*NIBBLE_W-1:0]   req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [NIBBLE_W-1:0]         link_data,
  output logic                        link_valid,
  input  logic                        link_ack,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned MAX_CYC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  link_state_t         r_state,   w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
  logic [IDX_W-1:0]    r_ptr,     w_ptr_nxt;
  logic [IDX_W-1:0]    r_grant,   w_grant_nxt;
  logic [NIBBLE_W-1:0] r_data,    w_data_nxt;
  logic                r_valid,   w_valid_nxt;
  logic [N_REQ-1:0]    r_ready,   w_ready_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_terr,    w_terr_nxt;

  logic [IDX_W-1:0]    w_pick;
  logic                w_any;
  logic [CNT_W-1:0]    w_cnt_inc;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_pick),
    .o_any_c   (w_any)
  );

  assign w_cnt_inc = (r_cnt == CNT_W'(MAX_CYC)) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state and next-output logic; every state entry clears the counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_ready_nxt = '0;
    w_terr_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_any) begin
          w_data_nxt  = req_data[w_pick*NIBBLE_W +: NIBBLE_W];
          w_valid_nxt = 1'b1;
          w_ready_nxt = N_REQ'(1) << w_pick;
          w_grant_nxt = w_pick;
          w_ptr_nxt   = w_pick;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (link_ack) begin
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = RELEASE;
        end else if (r_cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
          w_valid_nxt = 1'b0;
          w_terr_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end
      end
      RELEASE: begin
        if (!link_ack) begin
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end else if (r_cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
          w_terr_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_cnt >= CNT_W'(GAP_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_grant <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ready <= '0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  assign req_ready   = r_ready;
  assign link_data   = r_data;
  assign link_valid  = r_valid;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Directed bench for link_tx_arbiter with a registered-ack receiver model.
module tb_link_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  link_data;
  logic        link_valid;
  logic        link_ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  // receiver mode: 0 = normal (ack<=valid), 1 = dead (ack 0), 2 = stuck (ack 1)
  logic [1:0]  rx_mode;

  int n_tests = 0;
  int n_fail  = 0;

  link_tx_arbiter #(
    .N_REQ       (4),
    .NIBBLE_W    (4),
    .TIMEOUT_CYC (8),
    .GAP_CYC     (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .link_data   (link_data),
    .link_valid  (link_valid),
    .link_ack    (link_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) link_ack <= 1'b0;
    else begin
      case (rx_mode)
        2'd0:    link_ack <= link_valid;
        2'd1:    link_ack <= 1'b0;
        default: link_ack <= 1'b1;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_rise(input int budget, output int waited, output bit ok);
    logic prev;
    prev   = link_valid;
    ok     = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (link_valid && !prev) begin
        waited = i + 1;
        ok     = 1'b1;
        break;
      end
      prev = link_valid;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_data  = '0;
    rx_mode   = 2'd0;
    do_reset();
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", link_valid); end
    n_tests++; if (link_data !== 4'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", link_data); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr got %b exp 0", timeout_err); end
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_data  = 16'h0F00;
    step();
    n_tests++; if (link_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", link_valid); end
    n_tests++; if (link_data !== 4'hF) begin n_fail++; $display("FAIL single_data got %h exp F", link_data); end
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant got %0d exp 2", grant_id); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    req_valid = 4'b0000;
    step();
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_pulse got %b exp 0000", req_ready); end
    n_tests++; if (link_valid !== 1'b1 || link_ack !== 1'b1) begin n_fail++; $display("FAIL single_hold got valid=%b ack=%b exp 1/1", link_valid, link_ack); end
    step();
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b exp 0", link_valid); end
    step();
    step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_gap_busy got %b exp 1", busy); end
    step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", busy); end
  endtask

  task automatic test_rr_resume();
    int w;
    bit ok;
    req_valid = 4'b0101;
    req_data  = 16'h050A;
    step();
    n_tests++; if (grant_id !== 2'd0 || link_data !== 4'hA) begin n_fail++; $display("FAIL rr_first got grant=%0d data=%h exp 0/A", grant_id, link_data); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready got %b exp 0001", req_ready); end
    wait_rise(20, w, ok);
    n_tests++; if (!ok || w != 6) begin n_fail++; $display("FAIL rr_interval got ok=%0d cycles=%0d exp 1/6", ok, w); end
    n_tests++; if (grant_id !== 2'd2 || link_data !== 4'h5) begin n_fail++; $display("FAIL rr_second got grant=%0d data=%h exp 2/5", grant_id, link_data); end
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rr_second_ready got %b exp 0100", req_ready); end
    req_valid = 4'b0000;
    wait_idle(20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_fairness();
    int w;
    bit ok;
    logic [3:0] exp_d;
    logic [3:0] exp_r;
    req_valid = 4'b0000;
    do_reset();
    req_data  = 16'h3210;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_d = 4'(k % 4);
      exp_r = 4'b0001 << (k % 4);
      wait_rise(20, w, ok);
      n_tests++; if (!ok || w != ((k == 0) ? 1 : 6)) begin n_fail++; $display("FAIL fair_spacing[%0d] got ok=%0d cycles=%0d exp %0d", k, ok, w, (k == 0) ? 1 : 6); end
      n_tests++; if (link_data !== exp_d || req_ready !== exp_r) begin n_fail++; $display("FAIL fair_beat[%0d] got data=%h ready=%b exp %h/%b", k, link_data, req_ready, exp_d, exp_r); end
    end
    req_valid = 4'b0000;
    wait_idle(20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fair_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_dead_receiver();
    int hi;
    int readies;
    int w;
    bit ok;
    rx_mode   = 2'd1;
    req_valid = 4'b0010;
    req_data  = 16'h0070;
    step();
    n_tests++; if (link_valid !== 1'b1 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL dead_start got valid=%b ready=%b exp 1/0010", link_valid, req_ready); end
    req_valid = 4'b0000;
    hi = 1;
    readies = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready !== 4'b0000) readies++;
      if (link_valid) hi++;
      else break;
    end
    n_tests++; if (hi != 8) begin n_fail++; $display("FAIL dead_valid_len got %0d exp 8", hi); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL dead_terr got %b exp 1", timeout_err); end
    step();
    if (req_ready !== 4'b0000) readies++;
    n_tests++; if (timeout_err !== 1'b0 || link_valid !== 1'b0) begin n_fail++; $display("FAIL dead_terr_pulse got terr=%b valid=%b exp 0/0", timeout_err, link_valid); end
    n_tests++; if (readies != 1) begin n_fail++; $display("FAIL dead_no_replay got %0d ready pulses exp 1", readies); end
    rx_mode = 2'd0;
    wait_idle(10, ok);
    req_valid = 4'b1000;
    req_data  = 16'h9000;
    wait_rise(20, w, ok);
    n_tests++; if (!ok || link_data !== 4'h9 || grant_id !== 2'd3) begin n_fail++; $display("FAIL dead_recover got ok=%0d data=%h grant=%0d exp 1/9/3", ok, link_data, grant_id); end
    req_valid = 4'b0000;
    wait_idle(20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL dead_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_stuck_ack();
    int w;
    bit ok;
    int terrs;
    int terr_at;
    rx_mode   = 2'd0;
    req_valid = 4'b0001;
    req_data  = 16'h000C;
    wait_rise(20, w, ok);
    n_tests++; if (!ok || link_data !== 4'hC) begin n_fail++; $display("FAIL stuck_start got ok=%0d data=%h exp 1/C", ok, link_data); end
    req_valid = 4'b0000;
    rx_mode   = 2'd2;
    terrs   = 0;
    terr_at = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (timeout_err) begin
        terrs++;
        terr_at = i;
      end
    end
    n_tests++; if (terrs != 1 || terr_at != 10) begin n_fail++; $display("FAIL stuck_terr got count=%0d at=%0d exp 1/10", terrs, terr_at); end
    n_tests++; if (busy !== 1'b0 || link_valid !== 1'b0) begin n_fail++; $display("FAIL stuck_idle got busy=%b valid=%b exp 0/0", busy, link_valid); end
    rx_mode = 2'd0;
    step();
    step();
  endtask

  task automatic test_reset_mid_send();
    int w;
    bit ok;
    rx_mode   = 2'd1;
    req_data  = 16'h3210;
    req_valid = 4'b1111;
    wait_rise(20, w, ok);
    n_tests++; if (!ok || grant_id !== 2'd1) begin n_fail++; $display("FAIL midrst_pre got ok=%0d grant=%0d exp 1/1", ok, grant_id); end
    step();
    step();
    reset_n = 1'b0;
    #1;
    n_tests++; if (link_valid !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_async got valid=%b grant=%0d busy=%b ready=%b exp 0/0/0/0000", link_valid, grant_id, busy, req_ready); end
    step();
    @(negedge clk);
    reset_n = 1'b1;
    rx_mode = 2'd0;
    wait_rise(20, w, ok);
    n_tests++; if (!ok || grant_id !== 2'd0 || link_data !== 4'h0) begin n_fail++; $display("FAIL midrst_first got ok=%0d grant=%0d data=%h exp 1/0/0", ok, grant_id, link_data); end
    req_valid = 4'b0000;
    wait_idle(20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_idle got busy=%b exp 0", busy); end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rx_mode   = 2'd0;
    test_reset();
    test_single();
    test_rr_resume();
    test_fairness();
    test_dead_receiver();
    test_stuck_ack();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
